fb_port_sched: RTL and testbench

- Access scheduler for the ISP frame-buffer dual-port RAM: FB_DEPTH entries, shared port A (read/write), read-only port B, both with one-cycle registered-address read latency.
- Port A is shared between two requesters:
  - a sequential pixel writer (ISP output stream);
  - a random-access reader (AHB slave side).
- Port B is driven by a free-running raster scanner feeding the display path.
- Sits between the ISP pipeline / AHB slave and the RAM instance; the RAM's ports connect directly to the ram_* ports below.

---
 rtl/fb_port_sched.sv | 199 +++++++++++++++++++
 tb/tb_fb_port_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_sched.sv
// Frame-buffer access scheduler: shares RAM port A between a sequential pixel writer and a
// random-access reader, and drives port B from a free-running raster scanner.
module fb_port_sched #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FB_DEPTH   = 9680
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // Pixel writer
   input  logic                  wr_valid_i,
   input  logic                  wr_sof_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  wr_ready_o,
   output logic                  wr_frame_done_o,
   // Random-access reader
   input  logic                  rd_req_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic                  rd_ack_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_err_o,
   // Raster scanner
   input  logic                  scan_en_i,
   input  logic                  scan_start_i,
   output logic                  scan_valid_o,
   output logic [DATA_WIDTH-1:0] scan_data_o,
   output logic                  scan_last_o,
   // RAM
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_a_o,
   output logic [DATA_WIDTH-1:0] ram_din_a_o,
   input  logic [DATA_WIDTH-1:0] ram_dout_a_i,
   output logic [ADDR_WIDTH-1:0] ram_addr_b_o,
   input  logic [DATA_WIDTH-1:0] ram_dout_b_i
);

   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(FB_DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(FB_DEPTH);

   typedef enum logic [1:0] {RIdle, RIssue, RData, RAck} rd_state_e;
   typedef enum logic [0:0] {SIdle, SRun} scan_state_e;

   rd_state_e   rd_state_q, rd_state_d;
   scan_state_e scan_state_q, scan_state_d;

   logic                  rr_last_q, rr_last_d;   // 1: reader won the last contended grant
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic                  frame_done_q, frame_done_d;
   logic                  pend_err_q, pend_err_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_err_q, rd_err_d;
   logic [ADDR_WIDTH-1:0] scan_ptr_q, scan_ptr_d;
   logic                  scan_valid_q, scan_valid_d;
   logic                  scan_last_q, scan_last_d;

   logic                  rd_in_range;
   logic                  rd_want;
   logic                  rd_grant;
   logic                  wr_grant;
   logic                  wr_ready;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  scan_issue;

   // ---------------------------------------------------------------------------------------
   // Port A arbitration
   // ---------------------------------------------------------------------------------------
   always_comb begin
      rd_in_range = ({1'b0, rd_addr_i} < DepthExt);
      rd_want     = (rd_state_q == RIssue) && rd_in_range;
      // Writer has priority unless the reader is due its round-robin turn.
      wr_grant    = !rd_want || rr_last_q;
      rd_grant    = rd_want && (!wr_valid_i || !rr_last_q);
      wr_ready    = wr_valid_i && wr_grant;
      wr_addr     = wr_sof_i ? '0 : wr_ptr_q;
      rr_last_d   = (wr_valid_i && rd_want) ? rd_grant : rr_last_q;
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      frame_done_d = 1'b0;
      if (wr_ready) begin
         wr_ptr_d     = (wr_addr == LastAddr) ? '0 : wr_addr + 1'b1;
         frame_done_d = (wr_addr == LastAddr);
      end
   end

   always_comb begin
      ram_we_o     = wr_ready;
      ram_addr_a_o = '0;
      ram_din_a_o  = '0;
      if (wr_ready) begin
         ram_addr_a_o = wr_addr;
         ram_din_a_o  = wr_data_i;
      end else if (rd_grant) begin
         ram_addr_a_o = rd_addr_i;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Reader FSM
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_state_q <= RIdle;
      else        rd_state_q <= rd_state_d;
   end

   always_comb begin
      rd_state_d = rd_state_q;
      unique case (rd_state_q)
         RIdle:  if (rd_req_i) rd_state_d = RIssue;
         RIssue: if (!rd_in_range || rd_grant) rd_state_d = RData;
         RData:  rd_state_d = RAck;
         RAck:   rd_state_d = RIdle;
         default: rd_state_d = RIdle;
      endcase
   end

   always_comb begin
      rd_ack_o   = (rd_state_q == RAck);
      pend_err_d = pend_err_q;
      rd_data_d  = rd_data_q;
      rd_err_d   = rd_err_q;
      if (rd_state_q == RIssue) pend_err_d = !rd_in_range;
      if (rd_state_q == RData) begin
         rd_data_d = pend_err_q ? '0 : ram_dout_a_i;
         rd_err_d  = pend_err_q;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Scanner FSM
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) scan_state_q <= SIdle;
      else        scan_state_q <= scan_state_d;
   end

   always_comb begin
      scan_state_d = scan_state_q;
      unique case (scan_state_q)
         SIdle:   if (scan_en_i && scan_start_i) scan_state_d = SRun;
         SRun:    if (!scan_en_i) scan_state_d = SIdle;
         default: scan_state_d = SIdle;
      endcase
   end

   always_comb begin
      scan_issue   = (scan_state_q == SRun) && scan_en_i;
      scan_valid_d = scan_issue;
      scan_last_d  = scan_issue && (scan_ptr_q == LastAddr);
      scan_ptr_d   = scan_ptr_q;
      if ((scan_state_q == SIdle) && scan_en_i && scan_start_i) begin
         scan_ptr_d = '0;
      end else if (scan_issue) begin
         // A restart still issues the current address; the next one is 0.
         scan_ptr_d = (scan_start_i || (scan_ptr_q == LastAddr)) ? '0 : scan_ptr_q + 1'b1;
      end
   end

   always_comb begin
      ram_addr_b_o = scan_ptr_q;
      scan_valid_o = scan_valid_q;
      scan_last_o  = scan_last_q;
      scan_data_o  = scan_valid_q ? ram_dout_b_i : '0;
   end

   // ---------------------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_q    <= 1'b1;
         wr_ptr_q     <= '0;
         frame_done_q <= 1'b0;
         pend_err_q   <= 1'b0;
         rd_data_q    <= '0;
         rd_err_q     <= 1'b0;
         scan_ptr_q   <= '0;
         scan_valid_q <= 1'b0;
         scan_last_q  <= 1'b0;
      end else begin
         rr_last_q    <= rr_last_d;
         wr_ptr_q     <= wr_ptr_d;
         frame_done_q <= frame_done_d;
         pend_err_q   <= pend_err_d;
         rd_data_q    <= rd_data_d;
         rd_err_q     <= rd_err_d;
         scan_ptr_q   <= scan_ptr_d;
         scan_valid_q <= scan_valid_d;
         scan_last_q  <= scan_last_d;
      end
   end

   assign wr_ready_o      = wr_ready;
   assign wr_frame_done_o = frame_done_q;
   assign rd_data_o       = rd_data_q;
   assign rd_err_o        = rd_err_q;

endmodule

// File: tb/tb_fb_port_sched.sv
// Directed bench for fb_port_sched with a behavioural dual-port RAM (port B write-first).
module tb_fb_port_sched;

   localparam int unsigned AW = 14;
   localparam int unsigned DW = 8;
   localparam int unsigned FB = 9680;

   logic          clk;
   logic          rst_n;
   logic          wr_valid, wr_sof, wr_ready, wr_frame_done;
   logic [DW-1:0] wr_data;
   logic          rd_req, rd_ack, rd_err;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          scan_en, scan_start, scan_valid, scan_last;
   logic [DW-1:0] scan_data;
   logic          ram_we;
   logic [AW-1:0] ram_addr_a, ram_addr_b;
   logic [DW-1:0] ram_din_a, ram_dout_a, ram_dout_b;

   fb_port_sched #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .FB_DEPTH  (FB)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wr_valid_i     (wr_valid),
      .wr_sof_i       (wr_sof),
      .wr_data_i      (wr_data),
      .wr_ready_o     (wr_ready),
      .wr_frame_done_o(wr_frame_done),
      .rd_req_i       (rd_req),
      .rd_addr_i      (rd_addr),
      .rd_ack_o       (rd_ack),
      .rd_data_o      (rd_data),
      .rd_err_o       (rd_err),
      .scan_en_i      (scan_en),
      .scan_start_i   (scan_start),
      .scan_valid_o   (scan_valid),
      .scan_data_o    (scan_data),
      .scan_last_o    (scan_last),
      .ram_we_o       (ram_we),
      .ram_addr_a_o   (ram_addr_a),
      .ram_din_a_o    (ram_din_a),
      .ram_dout_a_i   (ram_dout_a),
      .ram_addr_b_o   (ram_addr_b),
      .ram_dout_b_i   (ram_dout_b)
   );

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] img [0:FB-1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr_a] <= ram_din_a;
      ram_dout_a <= mem[ram_addr_a];
      ram_dout_b <= (ram_we && ram_addr_a == ram_addr_b) ? ram_din_a : mem[ram_addr_b];
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int errs, lat, nw, nr, blocked;

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; wr_sof = 1'b0; wr_data = '0;
      rd_req = 1'b0; rd_addr = '0; scan_en = 1'b0; scan_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {wr_ready, wr_frame_done, rd_ack, rd_data, rd_err, scan_valid,
                              scan_data, scan_last, ram_we, ram_addr_a, ram_din_a, ram_addr_b}, 0);
      rst_n = 1'b1;
      tick();

      // Full frame stream
      errs = 0;
      for (int i = 0; i < int'(FB); i++) begin
         wr_valid = 1'b1; wr_sof = (i == 0); wr_data = DW'(i); img[i] = DW'(i);
         #1;
         if (!(wr_ready && ram_we && ram_addr_a == AW'(i) && ram_din_a == DW'(i) && !wr_frame_done))
            errs++;
         tick();
      end
      check("stream_beats", errs, 0);
      wr_valid = 1'b0; wr_sof = 1'b0;
      #1;
      check("frame_done_pulse", wr_frame_done, 1);
      wr_valid = 1'b1; wr_data = 8'h00;
      #1;
      check("wr_ptr_wrapped", {ram_we, ram_addr_a}, {1'b1, AW'(0)});
      tick();
      wr_valid = 1'b0;
      #1;
      check("frame_done_single", wr_frame_done, 0);

      // Uncontended read
      rd_req = 1'b1; rd_addr = AW'(100);
      tick();
      check("rd_grant_addr", {ram_we, ram_addr_a}, {1'b0, AW'(100)});
      lat = 1;
      while (!rd_ack && lat < 10) begin tick(); lat++; end
      check("rd_latency", lat, 3);
      check("rd_data_100", {rd_err, rd_data}, {1'b0, img[100]});
      rd_req = 1'b0;
      tick();

      // Writer held high while two back-to-back reads contend
      nw = 0; nr = 0; blocked = 0; errs = 0; lat = 0;
      for (int c = 0; c < 16; c++) begin
         wr_valid = 1'b1; wr_sof = (nw == 0); wr_data = 8'hA0 + DW'(nw);
         if (!rd_req && nr < 2) begin rd_req = 1'b1; rd_addr = AW'(500 + nr); lat = 0; end
         #1;
         if (wr_ready) begin
            if (!(ram_we && ram_addr_a == AW'(nw) && ram_din_a == wr_data)) errs++;
            img[nw] = wr_data;
            nw++;
         end else begin
            blocked++;
         end
         if (rd_ack) begin
            if (lat > 4 || rd_err || rd_data != img[500 + nr]) errs++;
            rd_req = 1'b0;
            nr++;
         end
         tick();
         if (rd_req) lat++;
      end
      wr_valid = 1'b0; wr_sof = 1'b0;
      check("contend_errs", errs, 0);
      check("contend_reads", nr, 2);
      check("contend_blocked", blocked, 2);
      check("contend_writes", nw, 14);

      // Out-of-range read
      rd_req = 1'b1; rd_addr = AW'(FB); lat = 0; errs = 0;
      #1;
      while (!rd_ack && lat < 8) begin
         if (ram_we || ram_addr_a != '0) errs++;
         tick();
         lat++;
      end
      check("oor_latency", lat, 3);
      check("oor_result", {rd_err, rd_data}, {1'b1, DW'(0)});
      check("oor_port_a_quiet", errs, 0);
      rd_req = 1'b0;
      tick();

      // Raster scan over more than one frame
      scan_en = 1'b1; scan_start = 1'b1;
      #1;
      check("scan_start_novalid", scan_valid, 0);
      tick();
      scan_start = 1'b0;
      #1;
      check("scan_first_addr", {scan_valid, ram_addr_b}, {1'b0, AW'(0)});
      tick();
      errs = 0;
      for (int k = 0; k < int'(FB) + 3; k++) begin
         if (!(scan_valid && scan_data == img[k % FB] && scan_last == ((k % FB) == FB - 1))) errs++;
         tick();
      end
      check("scan_beats", errs, 0);
      scan_en = 1'b0;
      #1;
      check("scan_inflight", {scan_valid, scan_data}, {1'b1, img[3]});
      tick();
      check("scan_stopped", scan_valid, 0);

      // Reset during a pending read and an active scan
      scan_en = 1'b1; scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      tick();
      tick();
      rd_req = 1'b1; rd_addr = AW'(200);
      tick();
      check("pre_reset_scan", scan_valid, 1);
      rst_n = 1'b0;
      #1;
      check("reset_mid_outputs", {wr_ready, wr_frame_done, rd_ack, rd_data, rd_err, scan_valid,
                                  scan_data, scan_last, ram_we, ram_addr_a, ram_din_a,
                                  ram_addr_b}, 0);
      tick();
      tick();
      rd_req = 1'b0; scan_en = 1'b0;
      rst_n = 1'b1;
      errs = 0;
      repeat (6) begin
         if (rd_ack || scan_valid) errs++;
         tick();
      end
      check("post_reset_quiet", errs, 0);
      rd_req = 1'b1; rd_addr = AW'(200); lat = 0;
      #1;
      while (!rd_ack && lat < 10) begin tick(); lat++; end
      check("post_reset_latency", lat, 3);
      check("post_reset_data", {rd_err, rd_data}, {1'b0, img[200]});
      rd_req = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
